dcache_axi_bridge: RTL
======================

Name: dcache_axi_bridge

Overview:
Converts the data cache's memory-side request/ready interface (m_* signals) into single-beat AXI read and write transactions. It sits directly downstream of the data cache, between the cache's memory port and the SoC AXI interconnect. It also serves the uncached MMIO path, which the cache forwards onto the same m_* signals. One outstanding transaction at a time; no bursts.

Parameters:
ADDR_W, 32, address width of m_a / AXI addresses
DATA_W, 32, data width (only 32 supported)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m_a  in  ADDR_W  request address from cache
m_din  in  32  write data from cache
m_strobe  in  1  request valid, held until m_ready
m_wen  in  4  byte enables for writes
m_size  in  2  0=byte, 1=half, 2=word
m_rw  in  1  0 read, 1 write
m_ready  out  1  one-cycle completion pulse
m_dout  out  32  read data, valid with m_ready and held afterwards
araddr  out  ADDR_W  AXI read address
arsize  out  3  AXI read size, {1'b0,m_size}
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
rdata  in  32  AXI read data
rresp  in  2  AXI read response
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
awaddr  out  ADDR_W  AXI write address
awsize  out  3  AXI write size
awvalid  out  1  AXI AW valid
awready  in  1  AXI AW ready
wdata  out  32  AXI write data
wstrb  out  4  AXI write strobes = m_wen
wvalid  out  1  AXI W valid
wready  in  1  AXI W ready
bresp  in  2  AXI write response
bvalid  in  1  AXI B valid
bready  out  1  AXI B ready
bus_err  out  1  sticky: a non-OKAY rresp/bresp was seen; cleared only by rst

Behaviour:
- Reset (rst sampled at clk edge): state=IDLE; all valid/ready outputs, m_ready and bus_err = 0; m_dout=0.
- Request capture: in IDLE with m_strobe=1, latch m_a/m_din/m_wen/m_size/m_rw into registers. All AXI outputs are driven from these latched registers, never directly from the m_* inputs.
- IDLE -> AR when m_rw=0; IDLE -> AW_W when m_rw=1. arvalid or awvalid+wvalid assert in the cycle after capture.
- AR: hold arvalid until arready; then -> R.
- R: rready=1. On rvalid: latch rdata into m_dout, OR (rresp!=0) into bus_err, -> DONE.
- AW_W: awvalid and wvalid are independent. Each deasserts after its own handshake; flags aw_done/w_done track completion. Handshakes may occur in the same cycle or in either order. When both flags are set -> B.
- B: bready=1. On bvalid: OR (bresp!=0) into bus_err, -> DONE.
- DONE: m_ready=1 for exactly this cycle -> HOLD.
- HOLD: one dead cycle in which m_strobe is ignored, because the cache may still present the completed request; then -> IDLE.
- Minimum latency with zero-wait AXI: read or write, capture -> m_ready in 4 cycles; back-to-back requests every 5 cycles.
- AXI len=0, burst=INCR, id=0 and wlast=1 are constants from the package and are tied off in the top-level wrapper.
- Error responses still complete normally; data is passed through unchanged.
- m_strobe falling mid-transaction is ignored; the AXI transaction runs to completion.
- rst mid-transaction abandons it immediately and drops all valids. The interconnect is reset together with this block.
- Address and strobes pass through unaligned and unmodified; size/strobe consistency is the cache's responsibility.

Decomposition:
- Package dcache_axi_pkg: state encoding (IDLE, AR, R, AW_W, B, DONE, HOLD), AXI_LEN=0, AXI_BURST_INCR=2'b01, AXI_ID=0, RESP_OKAY=2'b00.
- No sub-module. The AW/W dual-flag logic stays inline.

Test Plan:
- Word read, zero-wait slave returns 32'hDEADBEEF at m_a=32'h0000_1040 -> araddr=32'h0000_1040, arsize=3'd2, m_ready pulses 4 cycles after capture, m_dout=32'hDEADBEEF.
- Byte write m_wen=4'b0100, m_din=32'h00AB0000: slave gives wready 3 cycles before awready -> exactly one AW and one W handshake, wstrb=4'b0100, single m_ready after bvalid.
- Same-cycle awready/wready plus bvalid delayed 5 cycles -> m_ready only after bvalid; no second AW.
- m_strobe held high for 3 cycles after m_ready with the same request -> no second AXI transaction; new request accepted after HOLD.
- rresp=2'b10 on a read -> bus_err=1 stays set across later OKAY transactions; m_ready still pulses.
- rst asserted while in R with rvalid low -> next cycle arvalid=rready=m_ready=0, state IDLE; a fresh read then completes normally.

Source files
------------

// File: rtl/dcache_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_axi_pkg
// Description : Shared types and AXI tie-off constants for the data-cache
//               to AXI single-beat bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_axi_pkg;

  // Bridge sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4,
    ST_DONE = 3'd5,
    ST_HOLD = 3'd6
  } state_t;

  // Single-beat transaction tie-offs used by the wrapper around the bridge.
  localparam logic [7:0] AXI_LEN        = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_ID         = 4'd0;
  localparam logic       AXI_WLAST      = 1'b1;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

endpackage
`default_nettype wire

// File: rtl/dcache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dcache_axi_bridge
// Description : Turns the data cache memory-side strobe/ready port into
//               single-beat AXI read or write transactions, one at a time.
//               All AXI request fields come from registers latched at capture.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_axi_bridge
  import dcache_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // cache memory port
  input  logic [ADDR_W-1:0] m_a,
  input  logic [DATA_W-1:0] m_din,
  input  logic              m_strobe,
  input  logic [3:0]        m_wen,
  input  logic [1:0]        m_size,
  input  logic              m_rw,
  output logic              m_ready,
  output logic [DATA_W-1:0] m_dout,
  // AXI read address / data
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  // AXI write address / data / response
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              bus_err
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_wen;
  logic [1:0]          r_size;
  logic                r_aw_done;
  logic                r_w_done;
  logic [DATA_W-1:0]   r_dout;
  logic                r_bus_err;
  logic                w_capture;

  assign w_capture = (r_state == ST_IDLE) && m_strobe;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs, all decoded from registered state.
  always_comb begin
    w_state_nxt = r_state;
    arvalid     = 1'b0;
    rready      = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    m_ready     = 1'b0;
    case (r_state)
      ST_IDLE: if (m_strobe) w_state_nxt = m_rw ? ST_AW_W : ST_AR;
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) w_state_nxt = ST_R;
      end
      ST_R: begin
        rready = 1'b1;
        if (rvalid) w_state_nxt = ST_DONE;
      end
      ST_AW_W: begin
        // AW and W complete independently; leave once both have been taken.
        awvalid = !r_aw_done;
        wvalid  = !r_w_done;
        if ((r_aw_done || awready) && (r_w_done || wready)) w_state_nxt = ST_B;
      end
      ST_B: begin
        bready = 1'b1;
        if (bvalid) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        m_ready     = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      // Dead cycle: the cache may still be presenting the request just served.
      ST_HOLD: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, AW/W completion flags, read data and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wen     <= '0;
      r_size    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_dout    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr    <= m_a;
        r_wdata   <= m_din;
        r_wen     <= m_wen;
        r_size    <= m_size;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (awvalid && awready) r_aw_done <= 1'b1;
      if (wvalid && wready)   r_w_done  <= 1'b1;
      if (rready && rvalid) begin
        r_dout <= rdata;
        if (rresp != RESP_OKAY) r_bus_err <= 1'b1;
      end
      if (bready && bvalid && (bresp != RESP_OKAY)) r_bus_err <= 1'b1;
    end
  end

  assign araddr  = r_addr;
  assign awaddr  = r_addr;
  assign arsize  = {1'b0, r_size};
  assign awsize  = {1'b0, r_size};
  assign wdata   = r_wdata;
  assign wstrb   = r_wen;
  assign m_dout  = r_dout;
  assign bus_err = r_bus_err;

endmodule
`default_nettype wire
